// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   serial_sub_state_t   - control FSM states (idle, running, result ready)
//   SERIAL_SUB_WIDTH_MIN - smallest legal operand width
//   SERIAL_SUB_WIDTH_MAX - largest legal operand width
package serial_sub_pkg;

    localparam int unsigned SERIAL_SUB_WIDTH_MIN = 2;
    localparam int unsigned SERIAL_SUB_WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } serial_sub_state_t;

endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: combinational one-bit full subtractor, computes a - b - bin.
// Ports:
//   a, b   in  1 : minuend / subtrahend bit
//   bin    in  1 : borrow in
//   diff   out 1 : difference bit
//   bout   out 1 : borrow out
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    always_comb begin
        diff = a ^ b ^ bin;
        // Borrow when b exceeds a, or when the bits match and a borrow is pending.
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, diff = a - b - bin modulo 2^WIDTH, one bit per
// clock LSB first through a single registered borrow cell.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the registered signed-overflow port ovf.
// Ports:
//   clk, rst_n  in      : clock, asynchronous active-low reset
//   start       in  1   : request an operation (ignored while busy)
//   a, b        in  W   : operands, captured on an accepted start
//   bin         in  1   : borrow in, captured on an accepted start
//   busy        out 1   : operation in progress
//   done        out 1   : one-cycle pulse, result valid from here on
//   diff        out W   : result, held until the next completion
//   bout        out 1   : unsigned borrow out
//   ovf         out 1   : signed overflow (SERIAL_SUB_OVF_EN only)
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);

    if (WIDTH < SERIAL_SUB_WIDTH_MIN || WIDTH > SERIAL_SUB_WIDTH_MAX) begin : g_width_check
        $error("serial_sub: WIDTH out of legal range");
    end

    serial_sub_state_t state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              br_q, br_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic cell_diff;
    logic cell_bout;
    logic last_bit;
    logic accept;

    full_sub_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));
    // A start is honoured in idle and in the done cycle (back-to-back), never mid-run.
    assign accept   = start && (state_q != StRun);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            a_sh_d = a;
            b_sh_d = b;
            br_d   = bin;
            cnt_d  = '0;
        end else if (state_q == StRun) begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {cell_diff, res_q[WIDTH-1:1]};
            br_d   = cell_bout;
            cnt_d  = cnt_q + CntW'(1);
            if (last_bit) begin
                diff_d = res_d;
                bout_d = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                // On the last bit the shift registers hold the operand MSBs.
                ovf_d  = (a_sh_q[0] != b_sh_q[0]) && (cell_diff != a_sh_q[0]);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed self-checking bench for serial_sub at WIDTH=8.
// Builds with or without SERIAL_SUB_OVF_EN; ovf is checked only when present.
module tb_serial_sub;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    serial_sub #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
        check(tag, {63'd0, ovf}, {63'd0, exp});
`else
        if (exp === 1'bz) $display("%s", tag);
`endif
    endtask

    // Called on a negedge with the DUT idle or in its done cycle. Presents the
    // operands with start, then waits (bounded) for done and checks the result.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input logic [W-1:0] ed, input logic eb,
                          input logic eo, input int pulse_at, input bit hold);
        int lat;
        int bad;
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        a   = ~ta;
        b   = ~tb;
        bin = ~tbin;
        lat = 0;
        bad = 0;
        while (done !== 1'b1 && lat < 4 * W) begin
            if (busy !== 1'b1) bad++;
            if (lat == pulse_at) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h00;
            end else if (pulse_at >= 0 && lat == pulse_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W));
        check({tag, "_busy_run"}, 64'(bad), 64'd0);
        check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_diff"}, {56'd0, diff}, {56'd0, ed});
        check({tag, "_bout"}, {63'd0, bout}, {63'd0, eb});
        check_ovf({tag, "_ovf"}, eo);
        if (!hold) begin
            @(negedge clk);
            check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
            check({tag, "_idle_after"}, {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_diff", {56'd0, diff}, 64'd0);
        check("rst_bout", {63'd0, bout}, 64'd0);
        check_ovf("rst_ovf", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, -1, 1'b0);
        run_op("sub_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, -1, 1'b0);
        run_op("sub_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, -1, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, -1, 1'b0);

        // Start pulsed mid-run must not disturb the operation in flight.
        run_op("ignored_start", 8'h10, 8'h04, 1'b0, 8'h0C, 1'b0, 1'b0, 3, 1'b0);
        ndone = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("ignored_start_no_extra_done", 64'(ndone), 64'd0);

        // Start held high: results back to back, busy drops only in each done cycle.
        run_op("b2b_0", 8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0, -1, 1'b1);
        run_op("b2b_1", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, -1, 1'b1);
        run_op("b2b_2", 8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0, -1, 1'b0);

        // Asynchronous reset mid-run clears outputs at once and aborts the run.
        a     = 8'h55;
        b     = 8'h11;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_diff", {56'd0, diff}, 64'd0);
        check("abort_bout", {63'd0, bout}, 64'd0);
        check_ovf("abort_ovf", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        run_op("after_abort", 8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
